rv32i_if_stage: RTL

Instruction-fetch stage of the rv32i_pipeline core. Holds the program counter, issues word reads to the synchronous-read instruction memory, and delivers {pc, pc+4, instr} into the IF/ID pipeline register consumed by decode. Honours stall requests from the hazard unit without losing the in-flight fetch, and flushes on branch/jump redirects from EX.

---
 rtl/rv32i_pkg.sv | 16 +
 rtl/rv32i_if_skid.sv | 28 ++
 rtl/rv32i_if_stage.sv | 121 ++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared types and constants for the rv32i_pipeline front end.
// Provides the NOP encoding, the default reset PC and the IF/ID payload struct.
package rv32i_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic        valid;
    logic        misaligned;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } if_id_t;

endpackage

// File: rtl/rv32i_if_skid.sv
// One-entry skid buffer holding the fetch response that lands while decode stalls.
// Flush has priority over capture, capture over drain.
module rv32i_if_skid
  import rv32i_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   capture,
  input  logic   drain,
  input  if_id_t entry,
  output if_id_t held
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held <= '0;
    end else if (flush) begin
      held.valid <= 1'b0;
    end else if (capture) begin
      held <= entry;
    end else if (drain) begin
      held.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rv32i_if_stage.sv
// Instruction-fetch stage: PC, synchronous imem request, skid-protected IF/ID register.
// Optional IF_MISALIGN_CHECK_EN halts fetch on a misaligned redirect and emits one flagged NOP.
module rv32i_if_stage
  import rv32i_pkg::*;
#(
  parameter int          DEPTH_WORDS = 2048,
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  localparam int         AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_en,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_rdata,
  input  logic          stall,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  output logic          if_id_valid,
  output logic [31:0]   if_id_pc,
  output logic [31:0]   if_id_pc4,
  output logic [31:0]   if_id_instr,
  output logic          if_id_misaligned
);

  logic [31:0] pc_q;
  logic [31:0] f2_pc;
  logic [31:0] redirect_target;
  logic        f2_valid;
  logic        f2_mis;
  logic        halt;
  logic        mis_pending;
  logic        redirect_mis;
  logic        issue;
  if_id_t      f2_entry;
  if_id_t      skid_q;
  if_id_t      if_id_q;

`ifdef IF_MISALIGN_CHECK_EN
  assign redirect_mis     = (redirect_pc[1:0] != 2'b00);
  assign redirect_target  = redirect_pc;
  assign if_id_misaligned = if_id_q.misaligned;
`else
  logic unused_bits;
  assign redirect_mis     = 1'b0;
  assign redirect_target  = {redirect_pc[31:2], 2'b00};
  assign if_id_misaligned = 1'b0;
  assign unused_bits      = ^{redirect_pc[1:0], if_id_q.misaligned};
`endif

  assign issue     = !stall && !redirect_valid && !halt;
  assign imem_en   = !rst && issue;
  assign imem_addr = pc_q[AW+1:2];

  // A misaligned slot never reads memory; it carries a NOP down the pipe instead.
  assign f2_entry = '{valid:      f2_valid,
                      misaligned: f2_mis,
                      pc:         f2_pc,
                      pc4:        f2_pc + 32'd4,
                      instr:      f2_mis ? NOP_INSTR : imem_rdata};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      f2_pc       <= RESET_PC;
      f2_valid    <= 1'b0;
      f2_mis      <= 1'b0;
      halt        <= 1'b0;
      mis_pending <= 1'b0;
    end else if (redirect_valid) begin
      pc_q        <= redirect_target;
      f2_valid    <= 1'b0;
      f2_mis      <= 1'b0;
      halt        <= redirect_mis;
      mis_pending <= redirect_mis;
    end else if (stall) begin
      f2_valid <= 1'b0;
      f2_mis   <= 1'b0;
    end else if (issue) begin
      pc_q     <= pc_q + 32'd4;
      f2_pc    <= pc_q;
      f2_valid <= 1'b1;
      f2_mis   <= 1'b0;
    end else if (mis_pending) begin
      f2_pc       <= pc_q;
      f2_valid    <= 1'b1;
      f2_mis      <= 1'b1;
      mis_pending <= 1'b0;
    end else begin
      f2_valid <= 1'b0;
      f2_mis   <= 1'b0;
    end
  end

  rv32i_if_skid u_skid (
    .clk     (clk),
    .rst     (rst),
    .flush   (redirect_valid),
    .capture (stall && f2_valid),
    .drain   (!stall),
    .entry   (f2_entry),
    .held    (skid_q)
  );

  // The skid entry is always older than whatever is in flight, so it drains first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_id_q <= '0;
    end else if (redirect_valid) begin
      if_id_q.valid      <= 1'b0;
      if_id_q.misaligned <= 1'b0;
    end else if (!stall) begin
      if_id_q <= skid_q.valid ? skid_q : f2_entry;
    end
  end

  assign if_id_valid = if_id_q.valid;
  assign if_id_pc    = if_id_q.pc;
  assign if_id_pc4   = if_id_q.pc4;
  assign if_id_instr = if_id_q.instr;

endmodule
